// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read/write management frame per accepted command.
// Optional define MDIO_PRE_SUPPRESS_EN adds cmd_nopre, which skips the 32-bit preamble.
module mdio_master #(
  parameter int MDC_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        cmd_nopre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam int HW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(MDC_DIV - 1);

  typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [5:0]    bit_q, bit_d, next_bit;
  logic [31:0]   frame_q, frame_d, frame_cmd;
  logic          wr_q, wr_d;
  logic [15:0]   rx_q, rx_d;
  logic          cmd_ready_d, busy_d, rsp_valid_d, mdc_d, mdio_o_d, mdio_t_d;
  logic [15:0]   rsp_rdata_d;
  logic          nopre;

`ifdef MDIO_PRE_SUPPRESS_EN
  assign nopre = cmd_nopre;
`else
  assign nopre = 1'b0;
`endif

  // Post-preamble half of the frame: ST, OP, PHYAD, REGAD, TA, DATA (reads fill TA/DATA with 1s).
  assign frame_cmd = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy, cmd_reg,
                      cmd_write ? {2'b10, cmd_wdata} : 18'h3FFFF};
  assign next_bit  = bit_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    wr_d        = wr_q;
    rx_d        = rx_q;
    cmd_ready_d = 1'b0;
    busy_d      = busy;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    mdc_d       = mdc;
    mdio_o_d    = mdio_o;
    mdio_t_d    = mdio_t;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          frame_d     = frame_cmd;
          wr_d        = cmd_write;
          rx_d        = '0;
          half_d      = '0;
          mdc_d       = 1'b0;
          mdio_t_d    = 1'b0;
          if (nopre) begin
            state_d  = SHIFT;
            bit_d    = 6'd32;
            mdio_o_d = frame_cmd[31];
          end else begin
            state_d  = PRE;
            bit_d    = 6'd0;
            mdio_o_d = 1'b1;
          end
        end
      end
      PRE, SHIFT: begin
        if (half_q != HALF_LAST) begin
          half_d = half_q + HW'(1);
        end else begin
          half_d = '0;
          if (!mdc) begin
            mdc_d = 1'b1;
            if (!wr_q && bit_q >= 6'd48)
              rx_d = {rx_q[14:0], mdio_i};
          end else if (bit_q == 6'd63) begin
            state_d     = DONE;
            mdc_d       = 1'b0;
            mdio_o_d    = 1'b1;
            mdio_t_d    = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = wr_q ? 16'h0000 : rx_q;
          end else begin
            // Bits 32..63 map onto frame_q[31..0], i.e. index ~bit[4:0].
            bit_d = next_bit;
            mdc_d = 1'b0;
            if (next_bit[5]) begin
              state_d  = SHIFT;
              mdio_o_d = frame_q[~next_bit[4:0]];
            end else begin
              mdio_o_d = 1'b1;
            end
            mdio_t_d = !wr_q && (next_bit >= 6'd46);
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      half_q    <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      wr_q      <= 1'b0;
      rx_q      <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_t    <= 1'b1;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      wr_q      <= wr_d;
      rx_q      <= rx_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      mdc       <= mdc_d;
      mdio_o    <= mdio_o_d;
      mdio_t    <= mdio_t_d;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master at MDC_DIV=2: frames captured on every mdc rise and compared with
// a frame built from the command fields; a small PHY model answers reads.
module tb_mdio_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy = '0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
`ifdef MDIO_PRE_SUPPRESS_EN
  logic        cmd_nopre = 1'b0;
  localparam bit HAS_NOPRE = 1'b1;
`else
  localparam bit HAS_NOPRE = 1'b0;
`endif
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_t;
  logic        mdio_i = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  mdio_master #(.MDC_DIV(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
    .cmd_nopre(cmd_nopre),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PHY model state, set by the stimulus task at accept time.
  bit          phy_on = 1'b0;
  logic [15:0] phy_word = '0;
  int          first_bit = 0;
  int          base_rises = 0;
  int          last_rsp = 0;
  bit          b2b_pending = 1'b0;

  logic [63:0] cap_o = '0;
  logic [63:0] cap_t = '0;
  int          mdc_rises = 0;
  int          nb;

  always @(posedge mdc) begin
    cap_o = {cap_o[62:0], mdio_o};
    cap_t = {cap_t[62:0], mdio_t};
    mdc_rises = mdc_rises + 1;
    #1;
    nb = first_bit + (mdc_rises - base_rises);
    if (phy_on && nb >= 48 && nb <= 63) mdio_i = phy_word[63 - nb];
    else mdio_i = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                               input logic [15:0] wd, input bit nopre_in,
                               input logic [15:0] pdata, input bit pon,
                               input int noise, input int abort_at);
    int wait_n, t_acc, t_rsp, busy_low, ready_high, nbits;
    bit got_rsp, nopre;
    logic [63:0] full, m, rdmask, exp_t;
    logic [15:0] exp_rd;
    nopre = nopre_in && HAS_NOPRE;
    t_rsp = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
`ifdef MDIO_PRE_SUPPRESS_EN
    cmd_nopre = nopre;
`endif
    wait_n = 0;
    while (cmd_ready !== 1'b1 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("accept_wait", 64'(wait_n < 50), 64'd1);
    if (wait_n >= 50) begin
      cmd_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    if (b2b_pending) begin
      checkOutput("b2b_gap", 64'(t_acc - last_rsp), 64'd1);
      checkOutput("b2b_mdc_low", 64'(mdc), 64'd0);
      b2b_pending = 1'b0;
    end
    phy_on = pon && !wr;
    phy_word = pdata;
    first_bit = nopre ? 32 : 0;
    base_rises = mdc_rises;
    @(negedge clk);
    busy_low = 0; ready_high = 0; got_rsp = 1'b0;
    while (cyc - t_acc < 400) begin
      if (busy !== 1'b1) busy_low++;
      if (cmd_ready !== 1'b0) ready_high++;
      if (abort_at > 0 && (mdc_rises - base_rises) >= abort_at) begin
        cmd_valid = 1'b0;
        return;
      end
      if (rsp_valid === 1'b1) begin
        got_rsp = 1'b1;
        t_rsp = cyc;
        break;
      end
      if (noise != 0) begin
        cmd_valid = (noise == 1) ? 1'b1 : 1'($urandom);
        cmd_write = 1'($urandom); cmd_phy = 5'($urandom);
        cmd_reg = 5'($urandom); cmd_wdata = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("rsp_seen", 64'(got_rsp), 64'd1);
    if (!got_rsp) begin
      cmd_valid = 1'b0;
      return;
    end
    last_rsp = t_rsp;
    nbits = nopre ? 32 : 64;
    full = {32'hFFFF_FFFF, 2'b01, wr ? 2'b01 : 2'b10, phy, rg, 2'b10, wd};
    m = nopre ? 64'h0000_0000_FFFF_FFFF : '1;
    rdmask = wr ? '1 : ~64'h3FFFF;
    exp_t = wr ? 64'h0 : 64'h3FFFF;
    exp_rd = wr ? 16'h0000 : (pon ? pdata : 16'hFFFF);
    checkOutput("latency", 64'(t_rsp - t_acc), nopre ? 64'd129 : 64'd257);
    checkOutput("busy_frame", 64'(busy_low), 64'd0);
    checkOutput("ready_frame", 64'(ready_high), 64'd0);
    checkOutput("rise_count", 64'(mdc_rises - base_rises), 64'(nbits));
    checkOutput("frame_o", cap_o & m & rdmask, full & m & rdmask);
    checkOutput("frame_t", cap_t & m, exp_t & m);
    checkOutput("rdata", 64'(rsp_rdata), 64'(exp_rd));
    checkOutput("done_mdc", 64'(mdc), 64'd0);
    checkOutput("done_t", 64'(mdio_t), 64'd1);
    if (noise == 1) begin
      b2b_pending = 1'b1;
    end else begin
      cmd_valid = 1'b0;
      @(negedge clk);
      checkOutput("rsp_pulse", 64'(rsp_valid), 64'd0);
      checkOutput("ready_after", 64'(cmd_ready), 64'd1);
      checkOutput("busy_after", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mdc", 64'(mdc), 64'd0);
    checkOutput("rst_mdio_o", 64'(mdio_o), 64'd1);
    checkOutput("rst_mdio_t", 64'(mdio_t), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 64'(cmd_ready), 64'd1);

    $display("[TB] write phy=01 reg=00 data=1140");
    applyStimulus(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0, 1'b0, 0, 0);

    $display("[TB] back-to-back commands held valid");
    applyStimulus(1'b1, 5'h0A, 5'h11, 16'h5A5A, 1'b0, 16'h0, 1'b0, 1, 0);
    applyStimulus(1'b0, 5'h1F, 5'h1E, 16'h0, 1'b0, 16'h1234, 1'b1, 0, 0);

    $display("[TB] cmd_valid toggled while busy");
    applyStimulus(1'b1, 5'h05, 5'h09, 16'hC3A5, 1'b0, 16'h0, 1'b0, 2, 0);

    $display("[TB] read phy=03 reg=02 with PHY returning BEEF");
    applyStimulus(1'b0, 5'h03, 5'h02, 16'h0, 1'b0, 16'hBEEF, 1'b1, 0, 0);

    $display("[TB] reset during bit 40 of a write");
    applyStimulus(1'b1, 5'h01, 5'h04, 16'hFFFF, 1'b0, 16'h0, 1'b0, 0, 41);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_mdc", 64'(mdc), 64'd0);
    checkOutput("abort_mdio_t", 64'(mdio_t), 64'd1);
    checkOutput("abort_mdio_o", 64'(mdio_o), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("abort_rdata", 64'(rsp_rdata), 64'd0);
    checkOutput("abort_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n++;
    end
    checkOutput("abort_no_rsp", 64'(n), 64'd0);
    applyStimulus(1'b0, 5'h07, 5'h01, 16'h0, 1'b0, 16'h796D, 1'b1, 0, 0);

    if (HAS_NOPRE) begin
      $display("[TB] write without preamble");
      applyStimulus(1'b1, 5'h02, 5'h03, 16'hA55A, 1'b1, 16'h0, 1'b0, 0, 0);
    end

    $display("[TB] randomized commands");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                    1'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 2)), 0);
    end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
